compound_response_compactor: RTL and testbench

Downstream stage of the compound-circuit block. It consumes the five compound outputs (y1..y5) as one 5-bit response vector per valid cycle and compacts a fixed-length run of vectors into a MISR signature. It also counts ones per output and compares the final signature against an expected value, which gives a self-checking BIST tail for the combinational stage.

---
 rtl/compound_response_compactor_pkg.sv | 19 +
 rtl/compound_response_compactor_misr.sv | 31 +++
 rtl/compound_response_compactor.sv | 77 +++++++
 tb/tb_compound_response_compactor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/compound_response_compactor_pkg.sv
// compound_bist_pkg: shared FSM state codes, default MISR polynomial and response bit indices
// for the compound-circuit BIST tail.
package compound_bist_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    localparam int Y1 = 0;
    localparam int Y2 = 1;
    localparam int Y3 = 2;
    localparam int Y4 = 3;
    localparam int Y5 = 4;

endpackage

// File: rtl/compound_response_compactor_misr.sv
// misr: multiple-input signature register folding a 5-bit response vector into a SIG_W-bit
// Galois-style shift register each enabled cycle.
module misr
    import compound_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [4:0]       din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q, sig_d;

    // clear takes priority so a restart never folds in a vector from the same cycle
    always_comb
        sig_d = clear  ? '0 :
                enable ? ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din)) :
                sig_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;

    assign sig = sig_q;

endmodule

// File: rtl/compound_response_compactor.sv
// compound_response_compactor: compacts NUM_VECTORS response vectors into a MISR signature,
// counts ones per output and flags whether the final signature matches the golden value.
module compound_response_compactor
    import compound_bist_pkg::*;
#(
    parameter int               NUM_VECTORS = 64,
    parameter int               SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEFAULT_POLY),
    localparam int              CW          = $clog2(NUM_VECTORS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        y_in,
    input  logic              y_valid,
    input  logic [SIG_W-1:0]  expected_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CW-1:0]     vec_count,
    output logic [5*CW-1:0]   ones_count
);

    state_t              state_q, state_d;
    logic [CW-1:0]       vec_q, vec_d;
    logic [4:0][CW-1:0]  ones_q, ones_d;
    logic [SIG_W-1:0]    exp_q, exp_d, sig_next;
    logic                pass_q, pass_d;
    logic                go, acc, last;

    assign go       = start && state_q != RUN;
    assign acc      = y_valid && state_q == RUN;
    assign last     = acc && vec_q == CW'(NUM_VECTORS - 1);
    // pass must reflect the signature that the final vector produces, not the one before it
    assign sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(y_in);

    always_comb begin
        state_d = go ? RUN : last ? DONE : state_q;
        vec_d   = go ? '0 : acc ? vec_q + CW'(1) : vec_q;
        exp_d   = go ? expected_sig : exp_q;
        pass_d  = go ? 1'b0 : last ? sig_next == exp_q : pass_q;
        for (int k = Y1; k <= Y5; k++)
            ones_d[k] = go ? '0 : (acc && y_in[k]) ? ones_q[k] + CW'(1) : ones_q[k];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ones_q  <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ones_q  <= ones_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end

    misr #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (go),
        .enable (acc),
        .din    (y_in),
        .sig    (signature)
    );

    assign busy       = state_q == RUN;
    assign done       = state_q == DONE;
    assign pass       = pass_q;
    assign vec_count  = vec_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_compound_response_compactor.sv
// tb_compound_response_compactor: three instances (4, 17, 64 vectors) share one stimulus stream
// and are compared every cycle against a run-level reference model.
module tb_compound_response_compactor;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, y_valid = 1'b0;
    logic [4:0]  y_in = '0;
    logic [15:0] expected_sig = '0;

    logic [2:0]  busy, done, pass;
    logic [15:0] sig [3];
    logic [2:0]  vc0;
    logic [4:0]  vc1;
    logic [6:0]  vc2;
    logic [14:0] oc0;
    logic [24:0] oc1;
    logic [34:0] oc2;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    compound_response_compactor #(.NUM_VECTORS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid),
        .expected_sig(expected_sig), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .signature(sig[0]), .vec_count(vc0), .ones_count(oc0));
    compound_response_compactor #(.NUM_VECTORS(17)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid),
        .expected_sig(expected_sig), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .signature(sig[1]), .vec_count(vc1), .ones_count(oc1));
    compound_response_compactor #(.NUM_VECTORS(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid),
        .expected_sig(expected_sig), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .signature(sig[2]), .vec_count(vc2), .ones_count(oc2));

    // reference model: one record per run length, advanced from the protocol rules
    int          nv [3] = '{4, 17, 64};
    logic        m_run [3], m_fin [3], m_pass [3];
    logic [15:0] m_sig [3], m_exp [3];
    int          m_cnt [3];
    int          m_ones [3][5];

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [4:0] y);
        return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'd0, y};
    endfunction

    always @(posedge clk or negedge rst_n)
        for (int i = 0; i < 3; i++)
            if (!rst_n) begin
                m_run[i] <= 1'b0; m_fin[i] <= 1'b0; m_pass[i] <= 1'b0;
                m_sig[i] <= '0; m_exp[i] <= '0; m_cnt[i] <= 0;
                for (int k = 0; k < 5; k++) m_ones[i][k] <= 0;
            end else if (start && !m_run[i]) begin
                m_run[i] <= 1'b1; m_fin[i] <= 1'b0; m_pass[i] <= 1'b0;
                m_sig[i] <= '0; m_exp[i] <= expected_sig; m_cnt[i] <= 0;
                for (int k = 0; k < 5; k++) m_ones[i][k] <= 0;
            end else if (m_run[i] && y_valid) begin
                m_sig[i] <= misr_next(m_sig[i], y_in);
                m_cnt[i] <= m_cnt[i] + 1;
                for (int k = 0; k < 5; k++) m_ones[i][k] <= m_ones[i][k] + int'(y_in[k]);
                if (m_cnt[i] + 1 == nv[i]) begin
                    m_run[i]  <= 1'b0;
                    m_fin[i]  <= 1'b1;
                    m_pass[i] <= misr_next(m_sig[i], y_in) == m_exp[i];
                end
            end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [63:0] vcv, ocv;
        int cw;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin vcv = 64'(vc0); ocv = 64'(oc0); cw = 3; end
                1:       begin vcv = 64'(vc1); ocv = 64'(oc1); cw = 5; end
                default: begin vcv = 64'(vc2); ocv = 64'(oc2); cw = 7; end
            endcase
            chk($sformatf("model%0d busy", i), 64'(busy[i]), 64'(m_run[i]));
            chk($sformatf("model%0d done", i), 64'(done[i]), 64'(m_fin[i]));
            chk($sformatf("model%0d pass", i), 64'(pass[i]), 64'(m_pass[i]));
            chk($sformatf("model%0d sig", i), 64'(sig[i]), 64'(m_sig[i]));
            chk($sformatf("model%0d vec_count", i), vcv, 64'(m_cnt[i]));
            for (int k = 0; k < 5; k++)
                chk($sformatf("model%0d ones_y%0d", i, k + 1),
                    (ocv >> (k * cw)) & ((64'd1 << cw) - 64'd1), 64'(m_ones[i][k]));
        end
    endtask

    always @(negedge clk) if (rst_n) cmp_model();

    // drive one cycle at a falling edge, return at the next falling edge
    task automatic cyc(input logic s, input logic v, input logic [4:0] y, input logic [15:0] e);
        start = s; y_valid = v; y_in = y; expected_sig = e;
        @(negedge clk);
    endtask

    task automatic arst();
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 64'(busy), 0);
        chk("arst done", 64'(done), 0);
        chk("arst pass", 64'(pass), 0);
        chk("arst sig0", 64'(sig[0]), 0);
        chk("arst sig1", 64'(sig[1]), 0);
        chk("arst sig2", 64'(sig[2]), 0);
        chk("arst vc", {vc0, vc1, vc2}, 0);
        chk("arst ones0", 64'(oc0), 0);
        chk("arst ones1", 64'(oc1), 0);
        chk("arst ones2", 64'(oc2), 0);
        @(negedge clk);
        start = 1'b0; y_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic s; logic v; logic [4:0] y; logic [15:0] e;
        logic [15:0] sig; logic [2:0] vc; logic bz; logic dn; logic ps;
    } vec_t;
    vec_t tbl [17];

    initial begin
        // expectations for the 4-vector instance only
        tbl = '{
            '{1, 0, 5'h00, 16'h0008, 16'h0000, 3'd0, 1, 0, 0},
            '{0, 1, 5'h01, 16'h0000, 16'h0001, 3'd1, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0002, 3'd2, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0004, 3'd3, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0008, 3'd4, 0, 1, 1},
            '{0, 1, 5'h1f, 16'h0000, 16'h0008, 3'd4, 0, 1, 1},
            '{1, 0, 5'h00, 16'h0009, 16'h0000, 3'd0, 1, 0, 0},
            '{0, 1, 5'h01, 16'h0000, 16'h0001, 3'd1, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0002, 3'd2, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0004, 3'd3, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0008, 3'd4, 0, 1, 0},
            '{1, 1, 5'h1f, 16'h0000, 16'h0000, 3'd0, 1, 0, 0},
            '{0, 0, 5'h1f, 16'h0000, 16'h0000, 3'd0, 1, 0, 0},
            '{1, 1, 5'h01, 16'hffff, 16'h0001, 3'd1, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0002, 3'd2, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0004, 3'd3, 1, 0, 0},
            '{0, 1, 5'h00, 16'h0000, 16'h0008, 3'd4, 0, 1, 0}
        };
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
        chk("reset pass", 64'(pass), 0);
        chk("reset sig0", 64'(sig[0]), 0);
        chk("reset vc", {vc0, vc1, vc2}, 0);
        chk("reset ones", {oc0, oc1}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].y, tbl[i].e);
            chk($sformatf("tbl%0d sig", i), 64'(sig[0]), 64'(tbl[i].sig));
            chk($sformatf("tbl%0d vec_count", i), 64'(vc0), 64'(tbl[i].vc));
            chk($sformatf("tbl%0d busy", i), 64'(busy[0]), 64'(tbl[i].bz));
            chk($sformatf("tbl%0d done", i), 64'(done[0]), 64'(tbl[i].dn));
            chk($sformatf("tbl%0d pass", i), 64'(pass[0]), 64'(tbl[i].ps));
        end

        arst();
        cyc(1, 0, 5'h00, 16'h1021);
        cyc(0, 1, 5'h01, 16'h0000);
        repeat (16) cyc(0, 1, 5'h00, 16'h0000);
        chk("fb17 sig", 64'(sig[1]), 64'h1021);
        chk("fb17 done", 64'(done[1]), 1);
        chk("fb17 pass", 64'(pass[1]), 1);

        arst();
        cyc(1, 0, 5'h00, 16'h00c3);
        for (int j = 0; j < 4; j++) begin
            cyc(0, 1, 5'b10101, 16'h0000);
            cyc(j == 1, 0, 5'h00, 16'h0000);
            cyc(0, 0, 5'h1f, 16'h0000);
        end
        chk("gap ones", 64'(oc0), 64'({3'd4, 3'd0, 3'd4, 3'd0, 3'd4}));
        chk("gap vec_count", 64'(vc0), 4);
        chk("gap sig", 64'(sig[0]), 64'h00c3);
        chk("gap pass", 64'(pass[0]), 1);

        arst();
        cyc(1, 0, 5'h00, 16'h0000);
        repeat (10) cyc(0, 1, 5'h0a, 16'h0000);
        arst();
        cyc(1, 0, 5'h00, 16'h0000);
        for (int j = 1; j <= 64; j++) begin
            cyc(0, 1, 5'h00, 16'h0000);
            if (j == 63) chk("run64 early done", 64'(done[2]), 0);
        end
        chk("run64 done", 64'(done[2]), 1);
        chk("run64 pass", 64'(pass[2]), 1);
        chk("run64 sig", 64'(sig[2]), 0);
        chk("run64 vec_count", 64'(vc2), 64);

        for (int n = 0; n < 2000; n++)
            if (n % 500 == 499) arst();
            else cyc($urandom_range(11) == 0, $urandom_range(3) != 0, 5'($urandom),
                     $urandom_range(1) == 0 ? 16'h0000 : 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
